inst_rom_arbiter: RTL and testbench
===================================

// Module: inst_rom_arbiter
// PURPOSE
//  Shares the single read port of the instruction ROM between the IF stage (fetch) and a debug/loader read port.
//  Arbitrates with fixed IF priority plus a debug starvation guard. Range/alignment-checks each address.
//  Drives the ROM's ce/addr and returns registered read data with a one-cycle valid pulse.
//  Sits between pc_reg/if_id, the debug port and the combinational instruction ROM; raises a stall request to ctrl.
// PARAMETERS
//  ROM_AW     17  log2 of ROM word count (matches `InstMemNumLog2); word index = addr[ROM_AW+1:2]
//  MAX_WAIT   8   consecutive denied debug cycles before debug is forced a grant (1..2**CNT_W-1)
//  CNT_W      4   starvation counter width
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   asynchronous reset, active-low
//  if_req      in   1   IF fetch request, held until granted
//  if_addr     in   32  IF byte address (`InstAddrBus)
//  if_gnt      out  1   IF request accepted this cycle
//  if_rvalid   out  1   IF response valid (1-cycle pulse)
//  if_rdata    out  32  IF instruction (`InstBus)
//  if_rerr     out  1   IF response error (misaligned/out of range)
//  dbg_req     in   1   debug read request, held until granted
//  dbg_addr    in   32  debug byte address
//  dbg_gnt     out  1   debug request accepted this cycle
//  dbg_rvalid  out  1   debug response valid (1-cycle pulse)
//  dbg_rdata   out  32  debug read data
//  dbg_rerr    out  1   debug response error
//  flush       in   1   from ctrl: cancel the IF response of the current cycle's grant
//  stall_req   out  1   to ctrl: if_req & ~if_gnt
//  rom_ce      out  1   ROM chip enable (`ChipEnable/`ChipDisable)
//  rom_addr    out  32  ROM byte address
//  rom_inst    in   32  ROM data (combinational from rom_addr)
// BEHAVIOUR
//  - Reset (rst=0, async): all registered outputs 0, starve_cnt=0; responses pending at reset are dropped.
//  - Grant (combinational, at most one per cycle): dbg_gnt = dbg_req & (~if_req | starve_cnt==MAX_WAIT);
//    if_gnt = if_req & ~dbg_gnt.
//  - starve_cnt: +1 each cycle dbg_req & ~dbg_gnt, saturating at MAX_WAIT. Cleared on dbg_gnt or ~dbg_req.
//  - err = (addr[1:0]!=0) | (addr[31:ROM_AW+2]!=0) for the granted address.
//  - rom_ce = `ChipEnable only when a grant is issued and err=0; rom_addr = granted addr, else ZeroWord.
//  - Response register, updated at the edge after a grant (latency 1): granted side gets rvalid=1,
//    rdata = err ? ZeroWord : rom_inst, rerr = err. The other side's rvalid=0.
//  - rvalid deasserts the next cycle unless another grant occurs; back-to-back grants give one response per cycle.
//  - rdata/rerr hold the last value between responses.
//  - flush=1 in an IF-grant cycle: if_rvalid=0 next cycle, if_rdata unchanged. Debug responses are never affected by flush.
//  - No request: no grant, rom_ce disabled, responses idle; idle cycles do not change starve_cnt except clearing it.
//  - Requesters must hold req/addr stable until gnt; addr changes while denied are legal (last value is used).
// STRUCTURE
//  - Widths/enables (`InstAddrBus, `InstBus, `ZeroWord, `ChipEnable, `ChipDisable, `InstMemNumLog2) come from defines.v.
//    Add `StarveMax there as the MAX_WAIT default.
//  - One sub-module: arb_starve_ctr (saturating counter with clear, CNT_W wide, outputs the hit flag).
//  - Top level: grant logic + address checker (combinational), one response register set per port.
// TESTING
//  1 Hold rst=0 with random inputs -> all outputs 0, rom_ce=`ChipDisable. Release -> first grant behaves normally.
//  2 if_req=1, if_addr=0x00000008, ROM[2]=0x34011100 -> if_gnt same cycle, rom_addr=0x8,
//    next cycle if_rvalid=1, if_rdata=0x34011100, if_rerr=0.
//  3 if_req and dbg_req held high, MAX_WAIT=8 -> IF granted cycles 1-8, dbg_gnt on cycle 9 with stall_req=1 that cycle,
//    starve_cnt back to 0, IF granted cycle 10.
//  4 dbg_addr=0x00000006 -> dbg_gnt=1, rom_ce disabled, next cycle dbg_rvalid=1, dbg_rerr=1, dbg_rdata=0.
//    Repeat with 0x00100000 (ROM_AW=17) -> same error response.
//  5 IF grant on addr 0x4 with flush=1 in the same cycle -> if_rvalid stays 0. Immediate next grant -> normal response.
//  6 Assert rst low between a grant and the next edge -> no rvalid after reset; counters and outputs at 0.

Source files
------------

// File: rtl/inst_rom_arbiter_pkg.sv
// Shared widths, enable levels and address-check helper for the instruction ROM arbiter.
// Grant selection is encoded as an enum so the top can steer address and response paths from one decision.
package inst_rom_arbiter_pkg;

  localparam int INST_ADDR_W       = 32;
  localparam int INST_W            = 32;
  localparam int INST_MEM_NUM_LOG2 = 17;
  localparam int STARVE_MAX        = 8;
  localparam int STARVE_CNT_W      = 4;

  localparam logic [INST_W-1:0] ZERO_WORD    = '0;
  localparam logic              CHIP_ENABLE  = 1'b1;
  localparam logic              CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DBG  = 2'd2
  } gnt_sel_e;

  // A word address is bad when misaligned or when any bit above the ROM word index is set.
  function automatic logic addr_err(input logic [INST_ADDR_W-1:0] addr,
                                    input int unsigned rom_aw);
    logic [INST_ADDR_W-1:0] hi_mask;
    hi_mask = '1 << (rom_aw + 2);
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != '0);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied debug cycles; hit flags that debug must win next.
module arb_starve_ctr
  import inst_rom_arbiter_pkg::*;
#(
  parameter int CNT_W    = STARVE_CNT_W,
  parameter int MAX_WAIT = STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == MAX_CNT);

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the instruction ROM read port between IF fetch and a debug reader: IF has priority,
// debug is forced through after MAX_WAIT denied cycles; responses come back one cycle after the grant.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ROM_AW   = INST_MEM_NUM_LOG2,
  parameter int MAX_WAIT = STARVE_MAX,
  parameter int CNT_W    = STARVE_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [INST_ADDR_W-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [INST_W-1:0]      if_rdata,
  output logic                   if_rerr,
  input  logic                   dbg_req,
  input  logic [INST_ADDR_W-1:0] dbg_addr,
  output logic                   dbg_gnt,
  output logic                   dbg_rvalid,
  output logic [INST_W-1:0]      dbg_rdata,
  output logic                   dbg_rerr,
  input  logic                   flush,
  output logic                   stall_req,
  output logic                   rom_ce,
  output logic [INST_ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0]      rom_inst
);

  logic                   if_req_v;
  logic                   dbg_req_v;
  logic                   starve_hit;
  gnt_sel_e               gnt_sel;
  logic [INST_ADDR_W-1:0] gnt_addr;
  logic                   gnt_err;
  logic [INST_W-1:0]      rsp_data;

  // Requests are masked while reset is held so no grant or ROM access leaks out during reset.
  assign if_req_v  = if_req & rst;
  assign dbg_req_v = dbg_req & rst;

  always_comb begin
    gnt_sel  = GNT_NONE;
    gnt_addr = ZERO_WORD;
    if (dbg_req_v && (!if_req_v || starve_hit)) begin
      gnt_sel  = GNT_DBG;
      gnt_addr = dbg_addr;
    end else if (if_req_v) begin
      gnt_sel  = GNT_IF;
      gnt_addr = if_addr;
    end
  end

  assign if_gnt    = (gnt_sel == GNT_IF);
  assign dbg_gnt   = (gnt_sel == GNT_DBG);
  assign stall_req = if_req_v & ~if_gnt;
  assign gnt_err   = addr_err(gnt_addr, ROM_AW);
  assign rom_ce    = ((gnt_sel != GNT_NONE) && !gnt_err) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr  = gnt_addr;
  assign rsp_data  = gnt_err ? ZERO_WORD : rom_inst;

  arb_starve_ctr #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (dbg_req_v & ~dbg_gnt),
    .clr (~dbg_req_v | dbg_gnt),
    .hit (starve_hit)
  );

  // A flushed IF grant produces no response and leaves the previous data/error visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= ZERO_WORD;
      if_rerr   <= 1'b0;
    end else if (if_gnt && !flush) begin
      if_rvalid <= 1'b1;
      if_rdata  <= rsp_data;
      if_rerr   <= gnt_err;
    end else begin
      if_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= ZERO_WORD;
      dbg_rerr   <= 1'b0;
    end else if (dbg_gnt) begin
      dbg_rvalid <= 1'b1;
      dbg_rdata  <= rsp_data;
      dbg_rerr   <= gnt_err;
    end else begin
      dbg_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_inst_rom_arbiter;

  localparam int ROM_AW   = 17;
  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 4;

  logic        clk;
  logic        rst;
  logic        if_req, dbg_req, flush;
  logic [31:0] if_addr, dbg_addr;
  logic        if_gnt, if_rvalid, if_rerr;
  logic [31:0] if_rdata;
  logic        dbg_gnt, dbg_rvalid, dbg_rerr;
  logic [31:0] dbg_rdata;
  logic        stall_req, rom_ce;
  logic [31:0] rom_addr, rom_inst;

  int n_checks;
  int n_pass;

  // Behavioural model state
  int          m_starve;
  logic        m_if_rvalid, m_if_rerr, m_dbg_rvalid, m_dbg_rerr;
  logic [31:0] m_if_rdata, m_dbg_rdata;
  logic        m_last_if_gnt, m_last_dbg_gnt;

  inst_rom_arbiter #(.ROM_AW(ROM_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_rerr    (if_rerr),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dbg_rerr   (dbg_rerr),
    .flush      (flush),
    .stall_req  (stall_req),
    .rom_ce     (rom_ce),
    .rom_addr   (rom_addr),
    .rom_inst   (rom_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word 2 is fixed, everything else is a hash of the word index
  function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
    logic [31:0] idx;
    idx = byte_addr >> 2;
    if (idx == 32'd2) return 32'h34011100;
    return idx * 32'h9E3779B1 + 32'h01234567;
  endfunction

  assign rom_inst = rom_word(rom_addr);

  function automatic logic exp_err(input logic [31:0] a);
    return ((a % 4) != 0) || ({32'd0, a} >= (64'd1 << (ROM_AW + 2)));
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
      1:       return 32'h0008_0000 + ($urandom_range(0, 1023) * 4);
      2:       return 32'h0007_FFFC;
      default: return $urandom_range(0, 255) * 4;
    endcase
  endfunction

  task automatic model_clear();
    m_starve       = 0;
    m_if_rvalid    = 1'b0;
    m_if_rerr      = 1'b0;
    m_if_rdata     = 32'd0;
    m_dbg_rvalid   = 1'b0;
    m_dbg_rerr     = 1'b0;
    m_dbg_rdata    = 32'd0;
    m_last_if_gnt  = 1'b0;
    m_last_dbg_gnt = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs presented during the cycle
  task automatic model_edge();
    logic eg_if, eg_dbg;
    if (!rst) begin
      model_clear();
    end else begin
      eg_dbg = dbg_req && (!if_req || m_starve >= MAX_WAIT);
      eg_if  = if_req && !eg_dbg;
      m_if_rvalid  = 1'b0;
      m_dbg_rvalid = 1'b0;
      if (eg_if && !flush) begin
        m_if_rvalid = 1'b1;
        m_if_rerr   = exp_err(if_addr);
        m_if_rdata  = m_if_rerr ? 32'd0 : rom_word(if_addr);
      end
      if (eg_dbg) begin
        m_dbg_rvalid = 1'b1;
        m_dbg_rerr   = exp_err(dbg_addr);
        m_dbg_rdata  = m_dbg_rerr ? 32'd0 : rom_word(dbg_addr);
      end
      if (dbg_req && !eg_dbg) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
      else                    m_starve = 0;
      m_last_if_gnt  = eg_if;
      m_last_dbg_gnt = eg_dbg;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic fl);
    if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da; flush = fl;
  endtask

  task automatic test_reset();
    logic [103:0] obs;
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      drive($urandom_range(0, 1), rand_addr(), $urandom_range(0, 1), rand_addr(), $urandom_range(0, 1));
      @(negedge clk);
      obs = {if_gnt, if_rvalid, if_rerr, if_rdata, dbg_gnt, dbg_rvalid, dbg_rerr, dbg_rdata,
             stall_req, rom_ce, rom_addr};
      n_checks++;
      if (obs !== '0) $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", c, obs);
      else n_pass++;
      tick();
    end
    drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if_gnt, rom_ce, rom_addr} !== {1'b1, 1'b1, 32'h10})
      $display("[TB] FAIL first_grant: got gnt=%b ce=%b addr=%h expected 1 1 00000010", if_gnt, rom_ce, rom_addr);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({if_rvalid, if_rerr, if_rdata} !== {1'b1, 1'b0, rom_word(32'h10)})
      $display("[TB] FAIL first_response: got v=%b e=%b d=%h expected 1 0 %h", if_rvalid, if_rerr, if_rdata, rom_word(32'h10));
    else n_pass++;
    tick();
  endtask

  task automatic test_if_read();
    drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({if_gnt, rom_ce, rom_addr, stall_req} !== {1'b1, 1'b1, 32'h8, 1'b0})
      $display("[TB] FAIL if_grant: got gnt=%b ce=%b addr=%h stall=%b expected 1 1 00000008 0", if_gnt, rom_ce, rom_addr, stall_req);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({if_rvalid, if_rerr, if_rdata, dbg_rvalid} !== {1'b1, 1'b0, 32'h34011100, 1'b0})
      $display("[TB] FAIL if_response: got v=%b e=%b d=%h dv=%b expected 1 0 34011100 0", if_rvalid, if_rerr, if_rdata, dbg_rvalid);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h34011100})
      $display("[TB] FAIL if_rvalid_pulse: got v=%b d=%h expected 0 34011100", if_rvalid, if_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_starvation();
    logic [2:0] exp_g;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 32'h20, 1'b1, 32'h40, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_g = (k == 9) ? 3'b011 : 3'b100;
      n_checks++;
      if ({if_gnt, dbg_gnt, stall_req} !== exp_g)
        $display("[TB] FAIL starve_grant cycle %0d: got if/dbg/stall=%b expected %b", k, {if_gnt, dbg_gnt, stall_req}, exp_g);
      else n_pass++;
      if (k == 10) begin
        n_checks++;
        if ({dbg_rvalid, dbg_rerr, dbg_rdata, if_rvalid} !== {1'b1, 1'b0, rom_word(32'h40), 1'b0})
          $display("[TB] FAIL starve_dbg_response: got v=%b e=%b d=%h ifv=%b expected 1 0 %h 0",
                   dbg_rvalid, dbg_rerr, dbg_rdata, if_rvalid, rom_word(32'h40));
        else n_pass++;
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_dbg_error();
    logic [31:0] bad [2];
    bad[0] = 32'h0000_0006;
    bad[1] = 32'h0010_0000;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, bad[i], 1'b0);
      @(negedge clk);
      n_checks++;
      if ({dbg_gnt, rom_ce} !== 2'b10)
        $display("[TB] FAIL dbg_err_grant %h: got gnt=%b ce=%b expected 1 0", bad[i], dbg_gnt, rom_ce);
      else n_pass++;
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({dbg_rvalid, dbg_rerr, dbg_rdata} !== {1'b1, 1'b1, 32'h0})
        $display("[TB] FAIL dbg_err_response %h: got v=%b e=%b d=%h expected 1 1 00000000", bad[i], dbg_rvalid, dbg_rerr, dbg_rdata);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    prev = if_rdata;
    drive(1'b1, 32'h4, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1) $display("[TB] FAIL flush_grant: got %b expected 1", if_gnt);
    else n_pass++;
    tick();
    drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, prev})
      $display("[TB] FAIL flush_suppress: got v=%b d=%h expected 0 %h", if_rvalid, if_rdata, prev);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({if_rvalid, if_rerr, if_rdata} !== {1'b1, 1'b0, 32'h34011100})
      $display("[TB] FAIL flush_next_grant: got v=%b e=%b d=%h expected 1 0 34011100", if_rvalid, if_rerr, if_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [103:0] obs;
    drive(1'b1, 32'h8, 1'b1, 32'hC, 1'b0);
    #2;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    obs = {if_gnt, if_rvalid, if_rerr, if_rdata, dbg_gnt, dbg_rvalid, dbg_rerr, dbg_rdata,
           stall_req, rom_ce, rom_addr};
    n_checks++;
    if (obs !== '0) $display("[TB] FAIL reset_mid_outputs: got %h expected 0", obs);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if_rvalid, dbg_rvalid, if_rdata, dbg_rdata} !== '0)
      $display("[TB] FAIL reset_mid_after: got ifv=%b dbgv=%b ifd=%h dbgd=%h expected all 0",
               if_rvalid, dbg_rvalid, if_rdata, dbg_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic        eg_if, eg_dbg, er;
    logic [31:0] ea;
    for (int c = 0; c < 400; c++) begin
      if (!(if_req && !m_last_if_gnt))   if_req  = ($urandom_range(0, 2) != 0);
      if (!(dbg_req && !m_last_dbg_gnt)) dbg_req = ($urandom_range(0, 1) != 0);
      if_addr  = rand_addr();
      dbg_addr = rand_addr();
      flush    = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      eg_dbg = dbg_req && (!if_req || m_starve >= MAX_WAIT);
      eg_if  = if_req && !eg_dbg;
      ea     = eg_dbg ? dbg_addr : (eg_if ? if_addr : 32'd0);
      er     = exp_err(ea);
      n_checks++;
      if ({if_gnt, dbg_gnt, stall_req, rom_ce} !== {eg_if, eg_dbg, if_req && !eg_if, (eg_if || eg_dbg) && !er})
        $display("[TB] FAIL rand_grant cycle %0d: got if/dbg/stall/ce=%b expected %b", c,
                 {if_gnt, dbg_gnt, stall_req, rom_ce}, {eg_if, eg_dbg, if_req && !eg_if, (eg_if || eg_dbg) && !er});
      else n_pass++;
      n_checks++;
      if (rom_addr !== ea) $display("[TB] FAIL rand_rom_addr cycle %0d: got %h expected %h", c, rom_addr, ea);
      else n_pass++;
      n_checks++;
      if ({if_rvalid, if_rerr, if_rdata} !== {m_if_rvalid, m_if_rerr, m_if_rdata})
        $display("[TB] FAIL rand_if_rsp cycle %0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h", c,
                 if_rvalid, if_rerr, if_rdata, m_if_rvalid, m_if_rerr, m_if_rdata);
      else n_pass++;
      n_checks++;
      if ({dbg_rvalid, dbg_rerr, dbg_rdata} !== {m_dbg_rvalid, m_dbg_rerr, m_dbg_rdata})
        $display("[TB] FAIL rand_dbg_rsp cycle %0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h", c,
                 dbg_rvalid, dbg_rerr, dbg_rdata, m_dbg_rvalid, m_dbg_rerr, m_dbg_rdata);
      else n_pass++;
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    model_clear();
    #1;
    test_reset();
    test_if_read();
    test_starvation();
    test_dbg_error();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
